// File: rtl/syn_fifo_pkg.sv
// Shared types, default sizes and pointer arithmetic for the synchronous FIFO family.
package syn_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_AF_LEVEL   = 14;
    localparam int unsigned DEF_AE_LEVEL   = 2;

    // Fill level from wrap-bit pointers: difference modulo 2^ptr_width.
    function automatic int unsigned ptr_count(input int unsigned wr_ptr,
                                              input int unsigned rd_ptr,
                                              input int unsigned ptr_width);
        int unsigned mask;
        mask = (32'd1 << ptr_width) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, contents not reset.
module syn_fifo_mem
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_flex.sv
// Single-clock FIFO with standard/FWFT read mode, fill count, programmable flags and flush.
module syn_fifo_flex
    import syn_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_LEVEL   = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam fifo_mode_e  MODE       = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [PTR_WIDTH-1:0] AF_THR = PTR_WIDTH'(AF_LEVEL);
    localparam logic [PTR_WIDTH-1:0] AE_THR = PTR_WIDTH'(AE_LEVEL);

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr_nxt;
    logic [PTR_WIDTH-1:0]  rd_ptr_nxt;
    logic [PTR_WIDTH-1:0]  count_nxt;
    logic                  empty_nxt;
    logic                  full_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data;

    // Accept/reject decisions and next pointer state; flush overrides both requests.
    always_comb begin
        rd_acc        = rd_en & ~empty;
        wr_acc        = wr_en & (~full | rd_acc);
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr_nxt = rd_ptr + PTR_WIDTH'(1);
            end
            overflow_nxt  = wr_en & ~wr_acc;
            underflow_nxt = rd_en & empty;
        end
        count_nxt = PTR_WIDTH'(ptr_count(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), PTR_WIDTH));
        empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt  = (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
    end

    // Pointers, count and flags, all registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            empty        <= empty_nxt;
            full         <= full_nxt;
            almost_empty <= (count_nxt <= AE_THR);
            almost_full  <= (count_nxt >= AF_THR);
            overflow     <= overflow_nxt;
            underflow    <= underflow_nxt;
        end
    end

    syn_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~clr),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rd_data)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [DATA_WIDTH-1:0] data_q;

        // Registered read data: loads the head on an accepted read, otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (clr) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= rd_data;
            end
        end

        assign data_out = data_q;
    end else begin : g_fwft
        assign data_out = rd_data;
    end

endmodule

// File: tb/tb_syn_fifo_flex.sv
// Scoreboard bench: standard and FWFT instances share stimulus and a queue-based reference model.
module tb_syn_fifo_flex;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_empty, s_full, s_ae, s_af, s_ov, s_uf;
    logic          f_empty, f_full, f_ae, f_af, f_ov, f_uf;
    logic [CW-1:0] s_count, f_count;

    typedef struct {
        logic [CW-1:0] count;
        logic          empty;
        logic          full;
        logic          ae;
        logic          af;
        logic          ov;
        logic          uf;
        logic [DW-1:0] sdat;
        logic          fv;
        logic [DW-1:0] fdat;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] std_data;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    syn_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(s_dout), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
        .almost_full(s_af), .count(s_count), .overflow(s_ov), .underflow(s_uf)
    );

    syn_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_ae),
        .almost_full(f_af), .count(f_count), .overflow(f_ov), .underflow(f_uf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the state after the coming rising edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        exp_t e;
        int   n;
        logic rd_ok, wr_ok;
        @(negedge clk);
        wr_en = w; rd_en = r; clr = c; data_in = d;
        e.ov = 1'b0;
        e.uf = 1'b0;
        if (c) begin
            mq.delete();
            std_data = '0;
        end else begin
            n     = mq.size();
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            e.ov  = w && !wr_ok;
            e.uf  = r && (n == 0);
            if (rd_ok) std_data = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        e.count = CW'(mq.size());
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.ae    = (mq.size() <= 2);
        e.af    = (mq.size() >= 14);
        e.sdat  = std_data;
        e.fv    = (mq.size() > 0);
        e.fdat  = e.fv ? mq[0] : '0;
        exp_q.push_back(e);
    endtask

    task automatic check_reset();
        chk("rst_s_count", 32'(s_count), 0);
        chk("rst_s_empty", 32'(s_empty), 1);
        chk("rst_s_ae",    32'(s_ae),    1);
        chk("rst_s_full",  32'(s_full),  0);
        chk("rst_s_af",    32'(s_af),    0);
        chk("rst_s_ov",    32'(s_ov),    0);
        chk("rst_s_uf",    32'(s_uf),    0);
        chk("rst_s_dout",  32'(s_dout),  0);
        chk("rst_f_count", 32'(f_count), 0);
        chk("rst_f_empty", 32'(f_empty), 1);
        chk("rst_f_ae",    32'(f_ae),    1);
        chk("rst_f_full",  32'(f_full),  0);
        chk("rst_f_af",    32'(f_af),    0);
        chk("rst_f_ov",    32'(f_ov),    0);
        chk("rst_f_uf",    32'(f_uf),    0);
    endtask

    // Asynchronous reset asserted away from the clock edge and checked before any edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        #1;
        mq.delete();
        std_data = '0;
        check_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares both instances against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("s_count", 32'(s_count), 32'(e.count));
                chk("s_empty", 32'(s_empty), 32'(e.empty));
                chk("s_full",  32'(s_full),  32'(e.full));
                chk("s_ae",    32'(s_ae),    32'(e.ae));
                chk("s_af",    32'(s_af),    32'(e.af));
                chk("s_ov",    32'(s_ov),    32'(e.ov));
                chk("s_uf",    32'(s_uf),    32'(e.uf));
                chk("s_dout",  32'(s_dout),  32'(e.sdat));
                chk("f_count", 32'(f_count), 32'(e.count));
                chk("f_empty", 32'(f_empty), 32'(e.empty));
                chk("f_full",  32'(f_full),  32'(e.full));
                chk("f_ae",    32'(f_ae),    32'(e.ae));
                chk("f_af",    32'(f_af),    32'(e.af));
                chk("f_ov",    32'(f_ov),    32'(e.ov));
                chk("f_uf",    32'(f_uf),    32'(e.uf));
                if (e.fv) chk("f_dout", 32'(f_dout), 32'(e.fdat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        std_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x01..0x10, then one rejected write and an idle cycle.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
        step(1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain all sixteen, then one rejected read.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Single entry visible at the FWFT head without a read.
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Write and read together on an empty FIFO: only the write lands.
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Full with simultaneous write/read across pointer wrap.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        // Flush at count 8 with a write pending; the write must not land.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h00);

        // Reset mid-stream at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
        do_reset();

        // Random traffic biased toward filling, then toward draining, with occasional flush.
        for (int i = 0; i < 400; i++) begin
            int unsigned wp;
            wp = (i < 200) ? 70 : 30;
            step(1'($urandom_range(0, 99) < wp),
                 1'($urandom_range(0, 99) < (100 - wp)),
                 1'($urandom_range(0, 59) == 0),
                 DW'($urandom_range(0, 255)));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
